// File: rtl/group_pair_server.sv
// Responder for the trans_data/rece_data pair interface: compare-exchanges every
// lo/hi word pair, LANES pairs per cycle over a shared comparator bank.
module group_pair_server #(
    parameter int    DATA_WIDTH = 64,
    parameter int    PAIRS      = 8,
    parameter int    LANES      = 2,
    parameter string COM_STYLE  = "UP"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [2*PAIRS*DATA_WIDTH-1:0]   trans_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [2*PAIRS*DATA_WIDTH-1:0]   rece_data,
    output logic                            busy
);

    localparam int NBEAT = PAIRS / LANES;
    localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int VW    = 2 * PAIRS * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);
    localparam bit IS_DOWN = (COM_STYLE == "DOWN");

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [VW-1:0]   buf_q, buf_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;

    // Returns {new_hi, new_lo}; equal words never swap, so ties keep their positions.
    function automatic logic [2*DATA_WIDTH-1:0] cmp_exchange(
        input logic [DATA_WIDTH-1:0] lo,
        input logic [DATA_WIDTH-1:0] hi
    );
        logic swap;
        swap = IS_DOWN ? (lo < hi) : (lo > hi);
        return swap ? {lo, hi} : {hi, lo};
    endfunction

    // Next-state, beat and buffer update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    buf_d   = trans_data;
                    beat_d  = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int j = 0; j < LANES; j++) begin
                    int k;
                    k = int'(beat_q) * LANES + j;
                    buf_d[k*2*DATA_WIDTH +: 2*DATA_WIDTH] =
                        cmp_exchange(buf_q[(2*k)*DATA_WIDTH +: DATA_WIDTH],
                                     buf_q[(2*k+1)*DATA_WIDTH +: DATA_WIDTH]);
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = S_DONE;
                end else begin
                    beat_d  = beat_q + CW'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, buffer and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            buf_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            buf_q       <= buf_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rece_data = buf_q;

endmodule

// File: tb/tb_group_pair_server.sv
// Scoreboard bench: three instances (UP/LANES=2, DOWN/LANES=2, UP/LANES=1), all 8-bit x 4 pairs.
module tb_group_pair_server;

    localparam int DW = 8;
    localparam int P  = 4;
    localparam int VW = 2 * P * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rv   [3];
    logic          rr   [3];
    logic          sv   [3];
    logic          srdy [3];
    logic          bz   [3];
    logic [VW-1:0] td   [3];
    logic [VW-1:0] rd   [3];
    bit            rnd_en [3];

    typedef struct {
        int            id;
        logic [VW-1:0] d;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    group_pair_server #(.DATA_WIDTH(DW), .PAIRS(P), .LANES(2), .COM_STYLE("UP")) u_up (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .trans_data(td[0]),
        .rsp_valid(sv[0]), .rsp_ready(srdy[0]), .rece_data(rd[0]), .busy(bz[0]));
    group_pair_server #(.DATA_WIDTH(DW), .PAIRS(P), .LANES(2), .COM_STYLE("DOWN")) u_down (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .trans_data(td[1]),
        .rsp_valid(sv[1]), .rsp_ready(srdy[1]), .rece_data(rd[1]), .busy(bz[1]));
    group_pair_server #(.DATA_WIDTH(DW), .PAIRS(P), .LANES(1), .COM_STYLE("UP")) u_l1 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr[2]), .trans_data(td[2]),
        .rsp_valid(sv[2]), .rsp_ready(srdy[2]), .rece_data(rd[2]), .busy(bz[2]));

    function automatic int nbeat(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic bit is_down(input int i);
        return (i == 1);
    endfunction

    // Reference: every pair becomes (min,max) for UP or (max,min) for DOWN.
    function automatic logic [VW-1:0] model(input logic [VW-1:0] d, input bit down);
        logic [VW-1:0] r;
        logic [DW-1:0] lo, hi, mn, mx;
        r = d;
        for (int k = 0; k < P; k++) begin
            lo = d[16*k +: 8];
            hi = d[16*k+8 +: 8];
            mn = (lo < hi) ? lo : hi;
            mx = (lo < hi) ? hi : lo;
            r[16*k +: 8]   = down ? mx : mn;
            r[16*k+8 +: 8] = down ? mn : mx;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] pk(input int w0, w1, w2, w3, w4, w5, w6, w7);
        return {8'(w7), 8'(w6), 8'(w5), 8'(w4), 8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int w = 0; w < 2*P; w++) r[8*w +: 8] = 8'($urandom_range(0, 255));
        for (int k = 0; k < P; k++)
            if ($urandom_range(0, 3) == 0) r[16*k+8 +: 8] = r[16*k +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Present d on DUT i until accepted; returns just after the accept edge.
    task automatic send(input int i, input logic [VW-1:0] d, input bit keep, input bit push,
                        output time t_acc);
        bit ok;
        ok = 1'b0;
        rv[i] = 1'b1;
        td[i] = d;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (rr[i]) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        t_acc = $time;
        chk($sformatf("accept%0d", i), {63'd0, ok}, 64'd1);
        if (ok && push) sb.push_back('{i, model(d, is_down(i))});
        #1;
        if (!keep) begin
            rv[i] = 1'b0;
            td[i] = {$urandom, $urandom};
        end
    endtask

    // Counts cycles from the accept edge until rsp_valid, checking busy on the way.
    task automatic latency(input int i);
        int n;
        int busy_low;
        n = 0;
        busy_low = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n++;
            if (bz[i] !== 1'b1) busy_low++;
            if (sv[i] === 1'b1) break;
        end
        chk($sformatf("latency%0d", i), 64'(n), 64'(nbeat(i) + 1));
        chk($sformatf("busy%0d", i), 64'(busy_low), 64'd0);
    endtask

    // Monitor: rece_data must match the head expectation whenever rsp_valid is up.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                for (int i = 0; i < 3; i++) begin
                    if (sv[i] === 1'b1) begin
                        int idx;
                        idx = -1;
                        for (int q = 0; q < sb.size(); q++)
                            if (idx < 0 && sb[q].id == i) idx = q;
                        if (idx < 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_rsp%0d actual=%h required=none", i, rd[i]);
                        end else begin
                            chk($sformatf("rsp_data%0d", i), rd[i], sb[idx].d);
                            if (srdy[i] === 1'b1) sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    // Random rsp_ready for instances in the randomized phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                if (rnd_en[i]) srdy[i] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        time t1, t2;
        logic [VW-1:0] vec, x, y;
        int n, cnt;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; srdy[i] = 1'b1; td[i] = '0; rnd_en[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_req_ready%0d", i), 64'(rr[i]), 64'd1);
            chk($sformatf("rst_rsp_valid%0d", i), 64'(sv[i]), 64'd0);
            chk($sformatf("rst_busy%0d", i), 64'(bz[i]), 64'd0);
            chk($sformatf("rst_rece%0d", i), rd[i], '0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        vec = pk(9, 3, 1, 7, 5, 5, 200, 4);
        send(0, vec, 1'b0, 1'b1, t1);
        latency(0);
        chk("up_vec", rd[0], pk(3, 9, 1, 7, 5, 5, 4, 200));
        @(posedge clk); #1;

        send(1, vec, 1'b0, 1'b1, t1);
        latency(1);
        chk("down_vec", rd[1], pk(9, 3, 7, 1, 5, 5, 200, 4));
        @(posedge clk); #1;

        send(2, {VW{1'b1}}, 1'b0, 1'b1, t1);
        latency(2);
        chk("l1_all_ff", rd[2], {VW{1'b1}});
        @(posedge clk); #1;
        send(2, pk(8'h80, 8'h7f, 0, 1, 2, 2, 255, 0), 1'b0, 1'b1, t1);
        latency(2);
        chk("l1_unsigned", rd[2], pk(8'h7f, 8'h80, 0, 1, 2, 2, 0, 255));
        @(posedge clk); #1;

        // Backpressure: result held, new request refused until the handshake.
        x = rnd_vec();
        y = rnd_vec();
        srdy[0] = 1'b0;
        send(0, x, 1'b0, 1'b1, t1);
        latency(0);
        rv[0] = 1'b1;
        td[0] = y;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(sv[0]), 64'd1);
            chk("bp_data", rd[0], model(x, 1'b0));
            chk("bp_req_ready", 64'(rr[0]), 64'd0);
        end
        @(posedge clk); #1;
        srdy[0] = 1'b1;
        @(posedge clk);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n++;
            if (rr[0] === 1'b1) break;
        end
        chk("bp_idle_gap", 64'(n), 64'd1);
        @(posedge clk);
        sb.push_back('{0, model(y, 1'b0)});
        #1;
        rv[0] = 1'b0;
        latency(0);
        @(posedge clk); #1;

        // Back-to-back with req_valid held high.
        send(0, rnd_vec(), 1'b1, 1'b1, t1);
        send(0, rnd_vec(), 1'b0, 1'b1, t2);
        chk("b2b_spacing", 64'(t2 - t1), 64'((nbeat(0) + 2) * 10));
        latency(0);
        @(posedge clk); #1;

        // Reset after beat 0: abort with no response.
        send(0, rnd_vec(), 1'b0, 1'b0, t1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_req_ready", 64'(rr[0]), 64'd1);
        chk("abort_rsp_valid", 64'(sv[0]), 64'd0);
        chk("abort_rece", rd[0], '0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (sv[0] === 1'b1) cnt++;
        end
        chk("abort_no_rsp", 64'(cnt), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic on all three instances with random backpressure.
        for (int i = 0; i < 3; i++) rnd_en[i] = 1'b1;
        fork
            for (int t = 0; t < 15; t++) begin : f0
                time ta;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(0, rnd_vec(), 1'b0, 1'b1, ta);
            end
            for (int t = 0; t < 15; t++) begin : f1
                time ta;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(1, rnd_vec(), 1'b0, 1'b1, ta);
            end
            for (int t = 0; t < 15; t++) begin : f2
                time ta;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send(2, rnd_vec(), 1'b0, 1'b1, ta);
            end
        join
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            rnd_en[i] = 1'b0;
            srdy[i] = 1'b1;
        end
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/group_pair_server.md
Name: group_pair_server

Overview:
- Responder end of the trans_data/rece_data pair interface used by the sort group stages.
- Accepts one flat vector of 2*PAIRS words, where pair k = words 2k (lo) and 2k+1 (hi).
- Compare-exchanges every pair, time-multiplexed LANES pairs per cycle over a shared comparator bank, and returns the result on rece_data.
- Used where a full parallel com_mux array is too large: trades area for PAIRS/LANES cycles of latency, with valid/ready on both sides.

Parameters:
- DATA_WIDTH, 64: width of one word, unsigned.
- PAIRS, 8: pairs per transaction; PAIRS % LANES must be 0.
- LANES, 2: pairs compared per cycle; 1 <= LANES <= PAIRS.
- COM_STYLE, "UP": "UP" puts min in the lo word and max in the hi word; "DOWN" is the reverse.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  trans_data valid.
- req_ready  out  1  block can accept a request.
- trans_data  in  2*PAIRS*DATA_WIDTH  request words; word i at [i*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  out  1  rece_data holds a completed result.
- rsp_ready  in  1  consumer accepts the result.
- rece_data  out  2*PAIRS*DATA_WIDTH  result words, same packing as trans_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, beat counter=0, internal buffer=0.
  - req_ready=1, rsp_valid=0, busy=0, rece_data=0.
- FSM IDLE / RUN / DONE, with NBEAT = PAIRS/LANES and counter width clog2(NBEAT), minimum 1.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: buffer <= trans_data, beat <= 0, go to RUN.
  - Without req_valid, stay in IDLE; buffer holds.
- RUN (req_ready=0):
  - Each cycle, for lane j in 0..LANES-1, handle pair k = beat*LANES + j.
  - Compare lo = buf[2k] against hi = buf[2k+1], unsigned.
  - UP: buf[2k] <= min, buf[2k+1] <= max. DOWN: buf[2k] <= max, buf[2k+1] <= min.
  - Equal words are not swapped; both positions keep their value.
  - Pairs not addressed this beat hold their value.
  - beat increments. When beat = NBEAT-1, go to DONE on that edge; beat wraps to 0.
- DONE:
  - rsp_valid=1; rece_data=buffer, held stable until the handshake.
  - On rsp_valid&rsp_ready, go to IDLE. rsp_valid drops and req_ready rises the next cycle.
  - rsp_ready low holds DONE indefinitely, with the data stable.
- rece_data:
  - Always driven from the buffer.
  - Meaningful only while rsp_valid=1.
  - Shows partial results during RUN; the consumer must ignore it then.
- Latency:
  - Accept edge E0, then RUN for NBEAT edges.
  - rsp_valid is high in the cycle after edge E0+NBEAT, i.e. NBEAT+1 cycles after the accept cycle.
- No overlap: one transaction in flight at a time.
  - A request arriving in RUN or DONE is not accepted.
  - req_valid is held by the source (ready/valid rule); the block takes it after returning to IDLE.
- rsp_ready high in DONE plus req_valid already high: the new request is accepted in the IDLE cycle that follows, with no bubble beyond that single IDLE cycle.
- Reset asserted mid-RUN or mid-DONE: transaction aborted, all state and outputs return to reset values immediately.
- Handshake inputs sampled only on clk edges; X on trans_data is ignored outside the accept edge.

Test Plan:
- Config DATA_WIDTH=8, PAIRS=4, LANES=2, UP:
  - Stimulus: trans_data words [0..7] = 9,3, 1,7, 5,5, 200,4.
  - Response: rece_data = 3,9, 1,7, 5,5, 4,200; rsp_valid exactly 3 cycles after the accept cycle; busy=1 throughout.
- Same config, COM_STYLE="DOWN", same input -> rece_data = 9,3, 7,1, 5,5, 200,4.
- Backpressure:
  - Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid stays 1, rece_data unchanged, req_ready=0 with req_valid=1 asserted.
  - Raise rsp_ready -> next request accepted in the following IDLE cycle.
- Back-to-back: two requests with req_valid held high and rsp_ready=1 -> both correct; second accept edge exactly NBEAT+2 cycles after the first.
- Reset mid-RUN: assert rst for 1 cycle after beat 0 -> rece_data=0, rsp_valid=0, req_ready=1 asynchronously; no response ever issued for the aborted request.
- LANES=1, PAIRS=4, input all 0xFF -> no swaps, output equals input, rsp_valid 5 cycles after accept; unsigned check: pair 0x80,0x7F -> 0x7F,0x80 under UP.
